// File: rtl/divider_param_if.sv
// Operand/result bundle for divider_param: Start/Ack handshake, SCEN step enable, result and status.
// The master drives operands and control; the slave returns results and its one-hot state bits.
interface divider_param_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Xin;
    logic [WIDTH-1:0] Yin;
    logic             Start;
    logic             Ack;
    logic             SCEN;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivZero;
    logic [WIDTH-1:0] Cycles;
    logic             Qi;
    logic             Qc;
    logic             Qd;

    modport master (
        output Xin, Yin, Start, Ack, SCEN,
        input  Done, Quotient, Remainder, DivZero, Cycles, Qi, Qc, Qd
    );

    modport slave (
        input  Xin, Yin, Start, Ack, SCEN,
        output Done, Quotient, Remainder, DivZero, Cycles, Qi, Qc, Qd
    );
endinterface

// File: rtl/divider_param.sv
// Repeated-subtraction unsigned divider, up to STEPS subtractions per enabled clock, early exit.
// Latency max(1, ceil(q/STEPS)) SCEN-enabled clocks; result held in DONE_S until Ack.
module divider_param #(
    parameter int WIDTH = 8,
    parameter int STEPS = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    divider_param_if.slave  bus
);
    typedef enum logic [2:0] {
        S_INITIAL = 3'b001,
        S_COMPUTE = 3'b010,
        S_DONE    = 3'b100
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_cycles;
    logic             r_divzero;

    logic [WIDTH-1:0] w_xt;
    logic [WIDTH-1:0] w_qt;

    // Unrolled subtraction chain; a step whose trial would go negative passes its input through.
    always_comb begin
        w_xt = r_x;
        w_qt = r_q;
        for (int i = 0; i < STEPS; i++) begin
            if (w_xt >= r_y) begin
                w_xt = w_xt - r_y;
                w_qt = w_qt + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_INITIAL;
            r_x       <= '0;
            r_y       <= '0;
            r_q       <= '0;
            r_cycles  <= '0;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                S_INITIAL: begin
                    r_x       <= bus.Xin;
                    r_y       <= bus.Yin;
                    r_q       <= '0;
                    r_cycles  <= '0;
                    r_divzero <= 1'b0;
                    if (bus.Start) begin
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (bus.SCEN) begin
                        if (r_cycles != '1) begin
                            r_cycles <= r_cycles + WIDTH'(1);
                        end
                        if (r_y == '0) begin
                            r_q       <= '1;
                            r_divzero <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_x <= w_xt;
                            r_q <= w_qt;
                            if (w_xt < r_y) begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (bus.Ack) begin
                        r_state <= S_INITIAL;
                    end
                end
                default: r_state <= S_INITIAL;
            endcase
        end
    end

    assign bus.Done      = (r_state == S_DONE);
    assign bus.Qi        = r_state[0];
    assign bus.Qc        = r_state[1];
    assign bus.Qd        = r_state[2];
    assign bus.Quotient  = r_q;
    assign bus.Remainder = r_x;
    assign bus.Cycles    = r_cycles;
    assign bus.DivZero   = r_divzero;
endmodule

// File: tb/tb_divider_param.sv
// Bench for divider_param: three parameterisations share one handshake and are checked against
// a plain-arithmetic reference (quotient/remainder via / and %, cycle count via ceil(q/STEPS)).
module tb_divider_param;
    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Ack;
    logic        SCEN;
    logic [7:0]  xa;
    logic [7:0]  ya;
    logic [15:0] xc;
    logic [15:0] yc;

    int vectors;
    int miscompares;

    divider_param_if #(.WIDTH(8))  ifA ();
    divider_param_if #(.WIDTH(8))  ifB ();
    divider_param_if #(.WIDTH(16)) ifC ();

    assign ifA.Xin = xa;
    assign ifA.Yin = ya;
    assign ifA.Start = Start;
    assign ifA.Ack = Ack;
    assign ifA.SCEN = SCEN;
    assign ifB.Xin = xa;
    assign ifB.Yin = ya;
    assign ifB.Start = Start;
    assign ifB.Ack = Ack;
    assign ifB.SCEN = SCEN;
    assign ifC.Xin = xc;
    assign ifC.Yin = yc;
    assign ifC.Start = Start;
    assign ifC.Ack = Ack;
    assign ifC.SCEN = SCEN;

    divider_param #(.WIDTH(8),  .STEPS(2)) dutA (.Clk(Clk), .Reset(Reset), .bus(ifA));
    divider_param #(.WIDTH(8),  .STEPS(4)) dutB (.Clk(Clk), .Reset(Reset), .bus(ifB));
    divider_param #(.WIDTH(16), .STEPS(1)) dutC (.Clk(Clk), .Reset(Reset), .bus(ifC));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input int unsigned x, input int unsigned y,
                                    input int unsigned steps, input int unsigned width,
                                    output int unsigned q, output int unsigned r,
                                    output int unsigned cyc, output int unsigned dz);
        int unsigned ones;
        ones = (32'd1 << width) - 1;
        if (y == 0) begin
            q = ones; r = x; cyc = 1; dz = 1;
        end else begin
            q = x / y;
            r = x % y;
            cyc = (q == 0) ? 1 : (q + steps - 1) / steps;
            if (cyc > ones) cyc = ones;
            dz = 0;
        end
    endfunction

    task automatic check_res(input string n, input int unsigned x, input int unsigned y,
                             input int unsigned steps, input int unsigned width,
                             input logic [31:0] oq, input logic [31:0] orem,
                             input logic [31:0] oc, input logic odz, input logic odone);
        int unsigned q, r, c, dz;
        ref_div(x, y, steps, width, q, r, c, dz);
        check({n, "_done"}, {31'd0, odone}, 32'd1);
        check({n, "_quot"}, oq, q);
        check({n, "_rem"}, orem, r);
        check({n, "_cycles"}, oc, c);
        check({n, "_divzero"}, {31'd0, odz}, dz);
    endtask

    task automatic run_div(input logic [7:0] x8, input logic [7:0] y8,
                           input logic [15:0] x16, input logic [15:0] y16, input bit toggle);
        int unsigned qa, ra, ca, da, en, eq, er;
        bit pat [0:6];
        bit finished;
        logic sc;
        logic pdone;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
        ref_div(x8, y8, 2, 8, qa, ra, ca, da);
        @(negedge Clk);
        xa = x8; ya = y8; xc = x16; yc = y16; Start = 1'b1; SCEN = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        check("start_state", {29'd0, ifA.Qd, ifA.Qc, ifA.Qi}, 32'b010);
        en = 0;
        finished = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge Clk);
            if (ifA.Done && ifB.Done && ifC.Done) begin
                finished = 1;
                break;
            end
            sc = (toggle && k < 7) ? pat[k] : 1'b1;
            SCEN = sc;
            pdone = ifA.Done;
            @(posedge Clk);
            #1;
            if (!pdone) begin
                if (sc) en++;
                if (y8 == 0) begin
                    eq = (en > 0) ? 32'hFF : 0;
                    er = x8;
                end else begin
                    eq = (qa < en * 2) ? qa : en * 2;
                    er = x8 - eq * y8;
                end
                check("a_step_quot", ifA.Quotient, eq);
                check("a_step_rem", ifA.Remainder, er);
                check("a_step_cycles", ifA.Cycles, en);
                check("a_step_done", {31'd0, ifA.Done}, (en == ca) ? 1 : 0);
            end
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $error("FAIL timeout x=%0d y=%0d observed=not_done expected=done", x8, y8);
        end
        check_res("a", x8, y8, 2, 8, ifA.Quotient, ifA.Remainder, ifA.Cycles, ifA.DivZero, ifA.Done);
        check_res("b", x8, y8, 4, 8, ifB.Quotient, ifB.Remainder, ifB.Cycles, ifB.DivZero, ifB.Done);
        check_res("c", x16, y16, 1, 16, ifC.Quotient, ifC.Remainder, ifC.Cycles, ifC.DivZero, ifC.Done);
        Ack = 1'b1;
        Start = 1'b1;
        @(posedge Clk);
        #1 Ack = 1'b0;
        Start = 1'b0;
        check("ack_state_a", {29'd0, ifA.Qd, ifA.Qc, ifA.Qi}, 32'b001);
        check("ack_state_c", {29'd0, ifC.Qd, ifC.Qc, ifC.Qi}, 32'b001);
        check("ack_done_b", {31'd0, ifB.Done}, 32'd0);
        @(posedge Clk);
        #1;
        check("init_divzero_a", {31'd0, ifA.DivZero}, 32'd0);
        check("init_cycles_a", ifA.Cycles, 32'd0);
        check("init_quot_a", ifA.Quotient, 32'd0);
    endtask

    initial begin
        logic [7:0]  rx8, ry8;
        logic [15:0] rx16, ry16;
        vectors = 0;
        miscompares = 0;
        Reset = 1'b1; Start = 1'b0; Ack = 1'b0; SCEN = 1'b0;
        xa = '0; ya = '0; xc = '0; yc = '0;
        #1;
        check("rst_state", {29'd0, ifA.Qd, ifA.Qc, ifA.Qi}, 32'b001);
        check("rst_quot", ifA.Quotient, 32'd0);
        check("rst_rem", ifA.Remainder, 32'd0);
        check("rst_cycles", ifC.Cycles, 32'd0);
        check("rst_divzero", {31'd0, ifB.DivZero}, 32'd0);
        check("rst_done", {31'd0, ifA.Done}, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        run_div(8'd50, 8'd7, 16'd1000, 16'd1000, 1'b0);
        run_div(8'd5, 8'd9, 16'd5, 16'd9, 1'b0);
        run_div(8'd13, 8'd0, 16'd13, 16'd0, 1'b0);
        run_div(8'd255, 8'd1, 16'd255, 16'd1, 1'b0);
        run_div(8'd50, 8'd7, 16'd60000, 16'd1000, 1'b1);

        // Asynchronous reset landing between clock edges in the middle of a long division.
        @(negedge Clk);
        xa = 8'd200; ya = 8'd3; xc = 16'd200; yc = 16'd1; Start = 1'b1; SCEN = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("arst_state_a", {29'd0, ifA.Qd, ifA.Qc, ifA.Qi}, 32'b001);
        check("arst_quot_a", ifA.Quotient, 32'd0);
        check("arst_rem_a", ifA.Remainder, 32'd0);
        check("arst_cycles_a", ifA.Cycles, 32'd0);
        check("arst_state_c", {29'd0, ifC.Qd, ifC.Qc, ifC.Qi}, 32'b001);
        check("arst_quot_c", ifC.Quotient, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        run_div(8'd200, 8'd3, 16'd200, 16'd1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rx8 = 8'($urandom_range(0, 255));
            ry8 = 8'($urandom_range(0, 40));
            rx16 = 16'($urandom_range(0, 65535));
            ry16 = 16'(rx16 / 200 + $urandom_range(0, 300));
            run_div(rx8, ry8, rx16, ry16, bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
